// File: rtl/rr_slot_arbiter.sv
// Round-robin arbiter with a per-grant time-slice limit.
// One requester owns the shared resource at a time. A grant ends when the
// owner drops its request or after MAX_HOLD consecutive cycles. The next
// owner is picked in the same edge, searching upward from the old owner + 1.
module rr_slot_arbiter #(
   parameter int NREQ      = 4,
   parameter int MAX_HOLD  = 4,
   localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int HW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic            gnt_valid,
   output logic [IDW-1:0]  gnt_id,
   output logic [HW-1:0]   hold_cnt,
   output logic            expire
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [IDW-1:0] ID_LAST   = IDW'(NREQ - 1);

   // First requesting index at or after p, wrapping modulo NREQ.
   // Result is {found, index}.
   function automatic logic [IDW:0] pick_next(input logic [NREQ-1:0] r,
                                              input logic [IDW-1:0]  p);
      logic [IDW:0]   res;
      logic [IDW:0]   sum;
      logic [IDW-1:0] idx;
      res = '0;
      for (int i = 0; i < NREQ; i++) begin
         sum = {1'b0, p} + (IDW+1)'(i);
         if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
         idx = sum[IDW-1:0];
         if (!res[IDW] && r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] k);
      logic [NREQ-1:0] v;
      v    = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   state_t          state_q, state_d;
   logic [IDW-1:0]  owner_q, owner_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic            expire_q, expire_d;
   logic [NREQ-1:0] gnt_q, gnt_d;

   logic            release_slot;
   logic [IDW-1:0]  ptr_after;
   logic [IDW:0]    sel_idle;
   logic [IDW:0]    sel_rel;

   // State register; asynchronous active-low reset drops any grant at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         ptr_q    <= '0;
         hold_q   <= '0;
         expire_q <= 1'b0;
         gnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         ptr_q    <= ptr_d;
         hold_q   <= hold_d;
         expire_q <= expire_d;
         gnt_q    <= gnt_d;
      end
   end

   // Next-state: release/expiry detection and same-edge re-arbitration.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      ptr_d        = ptr_q;
      hold_d       = hold_q;
      expire_d     = 1'b0;
      gnt_d        = gnt_q;
      release_slot = 1'b0;
      sel_idle     = pick_next(req, ptr_q);
      ptr_after    = (owner_q == ID_LAST) ? '0 : owner_q + 1'b1;
      sel_rel      = pick_next(req, ptr_after);

      case (state_q)
         IDLE: begin
            if (en && sel_idle[IDW]) begin
               state_d = GRANT;
               owner_d = sel_idle[IDW-1:0];
               hold_d  = '0;
               gnt_d   = onehot(sel_idle[IDW-1:0]);
            end
         end
         GRANT: begin
            if (!req[owner_q]) begin
               release_slot = 1'b1;
            end else if (hold_q == HOLD_LAST) begin
               release_slot = 1'b1;
               expire_d     = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end

            // Rotation starts just past the departing owner, so it can only
            // win again when nobody else is asking.
            if (release_slot) begin
               ptr_d = ptr_after;
               if (en && sel_rel[IDW]) begin
                  owner_d = sel_rel[IDW-1:0];
                  hold_d  = '0;
                  gnt_d   = onehot(sel_rel[IDW-1:0]);
               end else begin
                  state_d = IDLE;
                  owner_d = '0;
                  hold_d  = '0;
                  gnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            owner_d = '0;
            hold_d  = '0;
            gnt_d   = '0;
         end
      endcase
   end

   assign gnt       = gnt_q;
   assign gnt_valid = |gnt_q;
   assign gnt_id    = owner_q;
   assign hold_cnt  = hold_q;
   assign expire    = expire_q;

endmodule

// File: tb/tb_rr_slot_arbiter.sv
// Directed bench for rr_slot_arbiter (NREQ=4, MAX_HOLD=4).
// Table rows are one cycle each: rst low applies reset between edges and is
// checked immediately; otherwise inputs are applied and outputs are checked
// just after the next rising edge.
module tb_rr_slot_arbiter;

   localparam int NREQ     = 4;
   localparam int MAX_HOLD = 4;

   logic       clk;
   logic       rst;
   logic       en;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       gnt_valid;
   logic [1:0] gnt_id;
   logic [1:0] hold_cnt;
   logic       expire;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst;
      logic       en;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] id;
      logic [1:0] hold;
      logic       exp;
   } vec_t;

   vec_t tbl[$];

   rr_slot_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id),
      .hold_cnt  (hold_cnt),
      .expire    (expire)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void add(input logic r, input logic e, input logic [3:0] rq,
                               input logic [3:0] g, input logic [1:0] id,
                               input logic [1:0] h, input logic x);
      vec_t v;
      v.rst = r; v.en = e; v.req = rq; v.gnt = g; v.id = id; v.hold = h; v.exp = x;
      tbl.push_back(v);
   endfunction

   task automatic cmp(input string nm, input int row, input string fld,
                      input logic [3:0] got, input logic [3:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s[%0d] %s: got %b want %b", nm, row, fld, got, want);
      end
   endtask

   task automatic check(input string nm, input int row, input logic [3:0] eg,
                        input logic [1:0] eid, input logic [1:0] eh, input logic ex);
      cmp(nm, row, "gnt",       gnt,               eg);
      cmp(nm, row, "gnt_valid", {3'b0, gnt_valid}, {3'b0, (eg != 4'b0)});
      cmp(nm, row, "gnt_id",    {2'b0, gnt_id},    {2'b0, eid});
      cmp(nm, row, "hold_cnt",  {2'b0, hold_cnt},  {2'b0, eh});
      cmp(nm, row, "expire",    {3'b0, expire},    {3'b0, ex});
   endtask

   task automatic step(input logic e, input logic [3:0] rq);
      en  = e;
      req = rq;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int h;
      int o;
      rst = 1'b0;
      en  = 1'b0;
      req = 4'b0;

      // Reset, then first grant from ptr 0 with req=1010 goes to requester 1.
      add(0, 1, 4'b1010, 4'b0000, 0, 0, 0);
      add(1, 1, 4'b1010, 4'b0010, 1, 0, 0);
      add(1, 1, 4'b0000, 4'b0000, 0, 0, 0);
      // Reset while idle brings ptr back to 0.
      add(0, 1, 4'b0000, 4'b0000, 0, 0, 0);
      // All request: owners 0,1,2,3,0 for 4 cycles each, expire on each handover.
      for (int k = 0; k < 17; k++) begin
         h = k % 4;
         o = (k / 4) % 4;
         add(1, 1, 4'b1111, 4'(1 << o), 2'(o), 2'(h), (k > 0 && h == 0));
      end
      // Voluntary release by owner 0 (ptr -> 1), back to idle.
      add(1, 1, 4'b0000, 4'b0000, 0, 0, 0);
      // Lone requester 2 for 12 cycles: re-granted every 4, expire on 3->0.
      for (int k = 0; k < 12; k++) begin
         h = k % 4;
         add(1, 1, 4'b0100, 4'b0100, 2, 2'(h), (k > 0 && h == 0));
      end
      add(1, 1, 4'b0000, 4'b0000, 0, 0, 0);
      // en low blocks new grants; dropping en mid-grant does not truncate it.
      add(1, 0, 4'b0011, 4'b0000, 0, 0, 0);
      add(1, 0, 4'b0011, 4'b0000, 0, 0, 0);
      add(1, 1, 4'b0011, 4'b0001, 0, 0, 0);
      add(1, 0, 4'b0011, 4'b0001, 0, 1, 0);
      add(1, 0, 4'b0011, 4'b0001, 0, 2, 0);
      add(1, 0, 4'b0011, 4'b0001, 0, 3, 0);
      add(1, 0, 4'b0011, 4'b0000, 0, 0, 1);
      add(1, 0, 4'b0011, 4'b0000, 0, 0, 0);

      #3;
      foreach (tbl[i]) begin
         if (!tbl[i].rst) begin
            rst = 1'b0;
            en  = tbl[i].en;
            req = tbl[i].req;
            #1;
         end else begin
            rst = 1'b1;
            step(tbl[i].en, tbl[i].req);
         end
         check("tbl", i, tbl[i].gnt, tbl[i].id, tbl[i].hold, tbl[i].exp);
      end

      // Wrap: ptr is 1, only requesters 0 and 3 pending; 3 wins, expires,
      // and the grant wraps to 0.
      step(1'b1, 4'b1001); check("wrap", 0, 4'b1000, 3, 0, 0);
      step(1'b1, 4'b1001); check("wrap", 1, 4'b1000, 3, 1, 0);
      step(1'b1, 4'b1001); check("wrap", 2, 4'b1000, 3, 2, 0);
      step(1'b1, 4'b1001); check("wrap", 3, 4'b1000, 3, 3, 0);
      step(1'b1, 4'b1001); check("wrap", 4, 4'b0001, 0, 0, 1);

      // Owner 0 drops; requester 1 holds 2 cycles, then drops with 3 pending.
      step(1'b1, 4'b1010); check("drop", 0, 4'b0010, 1, 0, 0);
      step(1'b1, 4'b1010); check("drop", 1, 4'b0010, 1, 1, 0);
      step(1'b1, 4'b1000); check("drop", 2, 4'b1000, 3, 0, 0);

      // Asynchronous reset in the middle of a grant, no clock edge needed.
      #2;
      rst = 1'b0;
      #1;
      check("async_rst", 0, 4'b0000, 0, 0, 0);
      #1;
      rst = 1'b1;
      step(1'b1, 4'b1010); check("async_rst", 1, 4'b0010, 1, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Cycle budget guard so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running want done");
      $fatal(1);
   end

endmodule

// File: doc/rr_slot_arbiter.md
Name: rr_slot_arbiter

Overview:
- Round-robin arbiter with a time-slice limit. Shares one single-owner resource (e.g. the memory port or the ALU) among NREQ requesters in the CPU.
- Grants are registered and one-hot. Each grant lasts at most MAX_HOLD cycles, tracked by an internal modulo hold counter, then rotates to the next requester.
- Sits between requesting units and the shared resource's mux select.

Parameters:
- NREQ, 4, number of requesters; must be >= 2; power of two not required.
- MAX_HOLD, 4, maximum consecutive cycles one grant may last; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset: asynchronous, active-low.
- en  input  1  when low, no new grant is issued; an existing grant runs to release/expiry.
- req  input  NREQ  request vector; bit i high = requester i wants the resource.
- gnt  output  NREQ  one-hot grant vector, registered; all-zero when idle.
- gnt_valid  output  1  high when any gnt bit is high.
- gnt_id  output  IDW = $clog2(NREQ)  index of current owner; 0 when idle.
- hold_cnt  output  HW = max(1, $clog2(MAX_HOLD))  cycles already spent in the current grant, 0-based.
- expire  output  1  one-cycle pulse: the previous grant was force-released by the time-slice limit.

Behaviour:
- Reset (rst low, no clock needed):
  - gnt=0, gnt_valid=0, gnt_id=0, hold_cnt=0, expire=0.
  - Rotation pointer ptr=0; state=IDLE.
  - Reset mid-grant drops the grant immediately.
- States:
  - IDLE: no owner.
  - GRANT: owner k, where gnt[k]=1.
- Selection function: the first i with req[i]=1, searching ptr, ptr+1, …, NREQ-1, 0, …, ptr-1, with modulo-NREQ wrap.
- IDLE:
  - If en=1 and req != 0: next edge enters GRANT with selected owner k, gnt=onehot(k), hold_cnt=0.
  - Latency: req seen at edge t, gnt visible after edge t.
- GRANT, owner k, evaluated at each edge, first match wins:
  - (a) req[k]=0: voluntary release; expire=0.
  - (b) req[k]=1 and hold_cnt==MAX_HOLD-1: forced release; expire=1 for the following cycle.
  - (c) otherwise: keep owner; hold_cnt++.
- On release:
  - ptr := (k+1) mod NREQ; same wrap rule as the counter, k==NREQ-1 gives 0.
  - Selection uses the new ptr, evaluated in the same edge, with no bubble cycle. If en=1 and a requester is found: grant it, hold_cnt=0. Otherwise go to IDLE and clear gnt.
  - k may be re-granted only if no other requester is pending.
- Hold limit: a holder that keeps req high receives exactly MAX_HOLD consecutive grant cycles before rotation. With MAX_HOLD=1, every grant lasts one cycle.
- Requester duty: a requester must ignore gnt during the cycle it has deasserted req. The grant drops at the next edge.
- en:
  - Sampled only for new grants; it never truncates a grant in progress.
  - en=0 with all grants released leaves the block in IDLE.
- Output invariants:
  - gnt is always zero or one-hot, and gnt_valid == |gnt.
  - gnt_id matches gnt.
  - expire is never high for two consecutive cycles unless back-to-back grants both expire.
- hold_cnt never exceeds MAX_HOLD-1.

Test Plan (NREQ=4, MAX_HOLD=4):
- Assert rst low mid-stream without a clock -> gnt=0000, gnt_valid=0, gnt_id=0, hold_cnt=0, expire=0 immediately. Release with req=1010 -> first grant is gnt=0010 (ptr reset to 0).
- Hold req=0100 for 12 cycles, en=1 ->
  - gnt=0100 continuously from the first edge.
  - hold_cnt sequence 0,1,2,3,0,1,2,3,….
  - expire pulses on each 3->0 transition.
- Hold req=1111 ->
  - Owners 0,1,2,3,0, each for exactly 4 cycles, with no idle cycle between them.
  - expire=1 on the first cycle of each new owner.
- Grant req[1] with req[3] also pending; drop req[1] after 2 grant cycles -> next edge gnt=1000, hold_cnt=0, expire=0.
- en=0 with req=0011 -> gnt stays 0000. Raise en -> gnt=0001 at the next edge. Drop en at hold_cnt=1 -> owner 0 keeps the grant through hold_cnt=3, then gnt=0000 and expire=1.
- Owner 3 expires with only req[0] and req[3] pending -> wrap: next gnt=0001, gnt_id=0.
